// File: rtl/ldpc_frame_scheduler.sv
// Frame sequencer in front of the bit-serial LDPC encoder: feeds bits, flushes, frames the output words.
// Optional stall statistics are enabled with LDPC_SCHED_STATS_EN.
module ldpc_frame_scheduler #(
    parameter int K_BITS       = 25920,
    parameter int INFO_WORDS   = 1440,
    parameter int PARITY_WORDS = 2160,
    parameter int FLUSH_CYCLES = 2,
    parameter int RST_CYCLES   = 4,
    parameter int TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic        s_bit,
    input  logic        s_sof,
    output logic        s_ready,
    output logic        enc_rst_n,
    output logic        enc_clk_enable,
    output logic        enc_bit,
    input  logic        enc_valid_out,
    input  logic [18:0] enc_data,
    output logic        m_valid,
    output logic [17:0] m_data,
    output logic        m_sof,
    output logic        m_eof,
    output logic        m_is_parity,
    output logic        frame_done,
    output logic        sof_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt,
    output logic [31:0] stall_cnt
);

    localparam int TOTAL_WORDS = INFO_WORDS + PARITY_WORDS;
    localparam int BW          = $clog2(K_BITS + 1);
    localparam int WW          = $clog2(TOTAL_WORDS + 1);
    localparam int TW          = $clog2(TIMEOUT + 1);
    localparam int PHASE_MAX   = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
    localparam int CW          = $clog2(PHASE_MAX + 1);

    localparam logic [BW-1:0] BIT_LAST    = BW'(K_BITS - 1);
    localparam logic [WW-1:0] WORD_LAST   = WW'(TOTAL_WORDS - 1);
    localparam logic [WW-1:0] WORD_PARITY = WW'(INFO_WORDS);
    localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENC_RST,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    state_t         r_state, w_state_next;
    logic [CW-1:0]  r_phase_cnt, w_phase_next;
    logic [BW-1:0]  r_bit_cnt, w_bit_next;
    logic [WW-1:0]  r_word_cnt, w_word_next;
    logic [TW-1:0]  r_idle_cnt, w_idle_next;

    logic           r_s_ready, w_s_ready_next;
    logic           r_enc_rst_n, w_enc_rst_n_next;
    logic           r_enc_en, w_enc_en_next;
    logic           r_enc_bit, w_enc_bit_next;
    logic           r_m_valid, w_m_valid_next;
    logic [17:0]    r_m_data, w_m_data_next;
    logic           r_m_sof, w_m_sof_next;
    logic           r_m_eof, w_m_eof_next;
    logic           r_m_parity, w_m_parity_next;
    logic           r_frame_done, w_frame_done_next;
    logic           r_sof_err, w_sof_err_next;
    logic           r_timeout_err, w_timeout_err_next;
    logic [15:0]    r_frame_cnt, w_frame_cnt_next;

    logic           w_accept;
    logic           w_unused_data_msb;

    assign w_accept          = s_valid & r_s_ready;
    assign w_unused_data_msb = enc_data[18];

    always_comb begin
        w_state_next       = r_state;
        w_phase_next       = r_phase_cnt;
        w_bit_next         = r_bit_cnt;
        w_word_next        = r_word_cnt;
        w_idle_next        = r_idle_cnt;
        w_enc_rst_n_next   = 1'b1;
        w_enc_en_next      = 1'b0;
        w_enc_bit_next     = 1'b0;
        w_m_valid_next     = 1'b0;
        w_m_data_next      = r_m_data;
        w_m_sof_next       = 1'b0;
        w_m_eof_next       = 1'b0;
        w_m_parity_next    = 1'b0;
        w_frame_done_next  = 1'b0;
        w_sof_err_next     = 1'b0;
        w_timeout_err_next = 1'b0;
        w_frame_cnt_next   = r_frame_cnt;

        case (r_state)
            ST_ENC_RST: begin
                w_enc_rst_n_next = 1'b0;
                w_bit_next       = '0;
                w_word_next      = '0;
                if (r_phase_cnt == RST_LAST) begin
                    w_state_next     = ST_FEED;
                    w_phase_next     = '0;
                    w_enc_rst_n_next = 1'b1;
                end else begin
                    w_phase_next = r_phase_cnt + CW'(1);
                end
            end
            ST_FEED: begin
                if (w_accept) begin
                    // A fresh SOF mid-frame means upstream restarted; drop this frame entirely.
                    if (s_sof && (r_bit_cnt != '0)) begin
                        w_sof_err_next   = 1'b1;
                        w_state_next     = ST_ENC_RST;
                        w_enc_rst_n_next = 1'b0;
                        w_phase_next     = '0;
                    end else begin
                        w_enc_en_next  = 1'b1;
                        w_enc_bit_next = s_bit;
                        w_bit_next     = r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = ST_FLUSH;
                            w_phase_next = '0;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                w_enc_en_next = 1'b1;
                if (r_phase_cnt == FLUSH_LAST) begin
                    w_state_next = ST_DRAIN;
                    w_phase_next = '0;
                    w_idle_next  = '0;
                end else begin
                    w_phase_next = r_phase_cnt + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (enc_valid_out) begin
                    w_m_valid_next  = 1'b1;
                    w_m_data_next   = enc_data[17:0];
                    w_m_sof_next    = (r_word_cnt == '0);
                    w_m_parity_next = (r_word_cnt >= WORD_PARITY);
                    w_word_next     = r_word_cnt + WW'(1);
                    w_idle_next     = '0;
                    // Leaving on the last word keeps the encoder's held-high valid_out from leaking through.
                    if (r_word_cnt == WORD_LAST) begin
                        w_m_eof_next      = 1'b1;
                        w_frame_done_next = 1'b1;
                        w_frame_cnt_next  = r_frame_cnt + 16'd1;
                        w_state_next      = ST_ENC_RST;
                        w_enc_rst_n_next  = 1'b0;
                        w_phase_next      = '0;
                    end
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_timeout_err_next = 1'b1;
                    w_state_next       = ST_ENC_RST;
                    w_enc_rst_n_next   = 1'b0;
                    w_phase_next       = '0;
                    w_idle_next        = '0;
                end else begin
                    w_idle_next = r_idle_cnt + TW'(1);
                end
            end
            default: begin
                w_state_next     = ST_ENC_RST;
                w_enc_rst_n_next = 1'b0;
                w_phase_next     = '0;
            end
        endcase

        w_s_ready_next = (w_state_next == ST_FEED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ENC_RST;
            r_phase_cnt   <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_s_ready     <= 1'b0;
            r_enc_rst_n   <= 1'b0;
            r_enc_en      <= 1'b0;
            r_enc_bit     <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_sof       <= 1'b0;
            r_m_eof       <= 1'b0;
            r_m_parity    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sof_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_phase_cnt   <= w_phase_next;
            r_bit_cnt     <= w_bit_next;
            r_word_cnt    <= w_word_next;
            r_idle_cnt    <= w_idle_next;
            r_s_ready     <= w_s_ready_next;
            r_enc_rst_n   <= w_enc_rst_n_next;
            r_enc_en      <= w_enc_en_next;
            r_enc_bit     <= w_enc_bit_next;
            r_m_valid     <= w_m_valid_next;
            r_m_data      <= w_m_data_next;
            r_m_sof       <= w_m_sof_next;
            r_m_eof       <= w_m_eof_next;
            r_m_parity    <= w_m_parity_next;
            r_frame_done  <= w_frame_done_next;
            r_sof_err     <= w_sof_err_next;
            r_timeout_err <= w_timeout_err_next;
            r_frame_cnt   <= w_frame_cnt_next;
        end
    end

`ifdef LDPC_SCHED_STATS_EN
    logic [31:0] r_stall_cnt;

    // Counts upstream starvation only once a frame is under way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_FEED) && (r_bit_cnt != '0) && !s_valid
                     && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

    assign s_ready        = r_s_ready;
    assign enc_rst_n      = r_enc_rst_n;
    assign enc_clk_enable = r_enc_en;
    assign enc_bit        = r_enc_bit;
    assign m_valid        = r_m_valid;
    assign m_data         = r_m_data;
    assign m_sof          = r_m_sof;
    assign m_eof          = r_m_eof;
    assign m_is_parity    = r_m_parity;
    assign frame_done     = r_frame_done;
    assign sof_err        = r_sof_err;
    assign timeout_err    = r_timeout_err;
    assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_ldpc_frame_scheduler.sv
// Scoreboard bench for ldpc_frame_scheduler with a small-frame configuration and a behavioural encoder.
module tb_ldpc_frame_scheduler;

    localparam int K     = 64;
    localparam int INFO  = 8;
    localparam int PAR   = 12;
    localparam int TOTAL = INFO + PAR;
    localparam int FLUSH = 2;
    localparam int RSTC  = 4;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid, s_bit, s_sof, s_ready;
    logic        enc_rst_n, enc_clk_enable, enc_bit;
    logic        enc_valid_out;
    logic [18:0] enc_data;
    logic        m_valid, m_sof, m_eof, m_is_parity;
    logic [17:0] m_data;
    logic        frame_done, sof_err, timeout_err;
    logic [15:0] frame_cnt;
    logic [31:0] stall_cnt;

    ldpc_frame_scheduler #(
        .K_BITS(K), .INFO_WORDS(INFO), .PARITY_WORDS(PAR),
        .FLUSH_CYCLES(FLUSH), .RST_CYCLES(RSTC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof), .s_ready(s_ready),
        .enc_rst_n(enc_rst_n), .enc_clk_enable(enc_clk_enable), .enc_bit(enc_bit),
        .enc_valid_out(enc_valid_out), .enc_data(enc_data),
        .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof),
        .m_is_parity(m_is_parity), .frame_done(frame_done), .sof_err(sof_err),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] data;
        logic        sof;
        logic        eof;
        logic        par;
    } word_t;

    word_t exp_q[$];
    bit    exp_bits[$];
    bit    rx_bits[$];

    int n_checks = 0;
    int n_fail   = 0;

    // encoder model controls
    int stop_after  = TOTAL;
    bit hold_mode   = 0;
    bit hold_active = 0;

    // monitor statistics
    int cyc = 0, words = 0, last_mv = 0, to_gap = 0;
    int sof_errs = 0, timeouts = 0, dones = 0;
    int rst_run = 0, last_rst_run = 0, en_run = 0, last_en_run = 0;

    int exp_fc = 0;
    int exp_stall = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_enc_rst_n"}, longint'(enc_rst_n), 0);
        chk({tag, "_s_ready"}, longint'(s_ready), 0);
        chk({tag, "_enc_drive"}, longint'({enc_clk_enable, enc_bit}), 0);
        chk({tag, "_m_word"}, longint'({m_valid, m_data, m_sof, m_eof, m_is_parity}), 0);
        chk({tag, "_pulses"}, longint'({frame_done, sof_err, timeout_err}), 0);
        chk({tag, "_frame_cnt"}, longint'(frame_cnt), 0);
        chk({tag, "_stall_cnt"}, longint'(stall_cnt), 0);
    endtask

    // which: 0 = frame end (frame_done or timeout_err), 1 = s_ready
    task automatic wait_sig(input int which, input int limit, input string name);
        int n = 0;
        bit hit = 0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? (frame_done | timeout_err) : s_ready;
        end
        if (!hit) chk({name, "_wait_expired"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int gap_pct, input int abort_at, input int rst_at, output int gaps);
        gaps = 0;
        exp_bits.delete();
        wait_sig(1, 200, "send_ready");
        for (int i = 0; i < K; i++) begin
            while (i > 0 && int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                gaps++;
                @(negedge clk);
            end
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset("async_rst");
                s_valid = 1'b0;
                s_sof   = 1'b0;
                return;
            end
            s_valid = 1'b1;
            s_bit   = 1'($urandom);
            s_sof   = (i == 0) || (i == abort_at);
            if (i != abort_at) exp_bits.push_back(s_bit);
            @(negedge clk);
            if (i == abort_at) break;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Behavioural encoder: collects enabled bits, then emits TOTAL words (or stop_after).
    initial begin : encoder_model
        int    en_count;
        int    word_idx;
        bit    emitting;
        word_t w;
        en_count = 0; word_idx = 0; emitting = 0;
        enc_valid_out = 1'b0;
        enc_data      = '0;
        forever begin
            @(negedge clk);
            if (enc_clk_enable) hold_active = 0;
            if (!enc_rst_n) begin
                en_count = 0; word_idx = 0; emitting = 0;
                rx_bits.delete();
            end else if (enc_clk_enable) begin
                rx_bits.push_back(enc_bit);
                en_count++;
                if (en_count == K + FLUSH) begin
                    bit ok;
                    ok = (exp_bits.size() == K);
                    for (int i = 0; i < K + FLUSH; i++) begin
                        if (i < K) begin
                            if (ok && rx_bits[i] != exp_bits[i]) ok = 0;
                        end else if (rx_bits[i] != 1'b0) ok = 0;
                    end
                    chk("enc_bit_stream", longint'(ok), 1);
                    emitting = 1;
                end else if (en_count > K + FLUSH) begin
                    chk("enc_extra_enable", longint'(en_count), K + FLUSH);
                end
            end
            if (emitting && word_idx < stop_after) begin
                if ($urandom_range(3) != 0) begin
                    w.data = 18'($urandom);
                    w.sof  = (word_idx == 0);
                    w.eof  = (word_idx == TOTAL - 1);
                    w.par  = (word_idx >= INFO);
                    enc_data      = {1'($urandom), w.data};
                    enc_valid_out = 1'b1;
                    exp_q.push_back(w);
                    word_idx++;
                    if (word_idx == TOTAL && hold_mode) hold_active = 1;
                end else begin
                    enc_valid_out = 1'b0;
                end
            end else if (hold_active) begin
                enc_valid_out = 1'b1;
                enc_data      = 19'($urandom);
            end else begin
                enc_valid_out = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    initial begin : monitor
        word_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                words++;
                last_mv = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", longint'(m_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_word_flags", longint'({m_data, m_sof, m_eof, m_is_parity}), longint'(e));
                    chk("frame_done_with_eof", longint'(frame_done), longint'(e.eof));
                end
            end else if (rst_n && (frame_done | m_sof | m_eof | m_is_parity)) begin
                chk("flags_without_valid", longint'({frame_done, m_sof, m_eof, m_is_parity}), 0);
            end
            if (sof_err) sof_errs++;
            if (timeout_err) begin
                timeouts++;
                to_gap = cyc - last_mv;
            end
            if (frame_done) dones++;
            if (!enc_rst_n) rst_run++;
            else begin
                if (rst_run != 0) last_rst_run = rst_run;
                rst_run = 0;
            end
            if (enc_clk_enable) en_run++;
            else begin
                if (en_run != 0) last_en_run = en_run;
                en_run = 0;
            end
        end
    end

    task automatic full_frame(input int gap_pct, input string tag);
        int g, w0;
        w0 = words;
        send_frame(gap_pct, -1, -1, g);
        exp_stall += g;
        wait_sig(0, 3000, {tag, "_end"});
        exp_fc++;
        chk({tag, "_frame_cnt"}, longint'(frame_cnt), exp_fc);
        chk({tag, "_words"}, longint'(words - w0), TOTAL);
        chk({tag, "_scoreboard_empty"}, longint'(exp_q.size()), 0);
        if (gap_pct == 0) chk({tag, "_enable_run"}, longint'(last_en_run), K + FLUSH);
`ifdef LDPC_SCHED_STATS_EN
        chk({tag, "_stall_cnt"}, longint'(stall_cnt), exp_stall);
`else
        chk({tag, "_stall_cnt"}, longint'(stall_cnt), 0);
`endif
        wait_sig(1, 50, {tag, "_next_ready"});
        chk({tag, "_enc_rst_len"}, longint'(last_rst_run), RSTC);
        $display("frame %s: gaps=%0d words=%0d frame_cnt=%0d", tag, g, words - w0, frame_cnt);
    endtask

    initial begin : main
        int g, w0, base;
        s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        full_frame(0, "continuous");
        full_frame(50, "gapped");

        // SOF mid-frame aborts without producing output
        base = sof_errs; w0 = words;
        send_frame(0, 10, -1, g);
        wait_sig(1, 50, "abort_ready");
        chk("abort_sof_err_pulses", longint'(sof_errs - base), 1);
        chk("abort_no_words", longint'(words - w0), 0);
        chk("abort_enc_rst_len", longint'(last_rst_run), RSTC);
        chk("abort_frame_cnt", longint'(frame_cnt), exp_fc);
        $display("abort: sof_err pulses=%0d frame_cnt=%0d", sof_errs - base, frame_cnt);
        full_frame(0, "after_abort");

        // Encoder stalls after 7 words
        stop_after = 7;
        base = timeouts; w0 = words;
        send_frame(25, -1, -1, g);
        exp_stall += g;
        wait_sig(0, 3000, "timeout_end");
        chk("timeout_pulses", longint'(timeouts - base), 1);
        chk("timeout_gap", longint'(to_gap), TO);
        chk("timeout_words", longint'(words - w0), 7);
        chk("timeout_frame_cnt", longint'(frame_cnt), exp_fc);
        chk("timeout_scoreboard_empty", longint'(exp_q.size()), 0);
        $display("timeout: words=%0d gap=%0d frame_cnt=%0d", words - w0, to_gap, frame_cnt);
        stop_after = TOTAL;
        wait_sig(1, 50, "timeout_ready");

        // Encoder holds valid_out high after the last word
        hold_mode = 1;
        full_frame(0, "hold_a");
        full_frame(30, "hold_b");
        hold_mode = 0;

        // Asynchronous reset in the middle of a frame
        send_frame(0, -1, 30, g);
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_fc = 0;
        exp_stall = 0;
        hold_active = 0;
        rst_n = 1'b1;
        $display("mid-frame reset applied and released");
        full_frame(0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
